// File: rtl/ram_copy_engine.sv
// Word-copy initiator for the fixed-latency simulation RAM port: reads len words from src_addr,
// one per cycle, and writes each returned word to dst_addr as it arrives.
module ram_copy_engine #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int READ_DELAY  = 1,
  parameter int WRITE_DELAY = 1,
  parameter int LEN_WIDTH   = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_addr,
  input  logic [ADDR_WIDTH-1:0]     dst_addr,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     raddr,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH-1:0]     rdata
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int CNT_WIDTH  = (WRITE_DELAY > 1) ? $clog2(WRITE_DELAY) : 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BYTES);
  localparam logic [CNT_WIDTH-1:0]  COMMIT_LAST = CNT_WIDTH'(WRITE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic [ADDR_WIDTH-1:0]   raddr_reg;
  logic [ADDR_WIDTH-1:0]   dst_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [LEN_WIDTH-1:0]    rd_cnt_reg;
  logic [CNT_WIDTH-1:0]    commit_cnt_reg;
  logic [CNT_WIDTH-1:0]    commit_cnt_next;
  logic [ADDR_WIDTH-1:0]   waddr_hold_reg;
  logic [DATA_WIDTH-1:0]   wdata_hold_reg;

  // One tag per outstanding read: valid flag plus destination word index.
  logic                    tag_valid_reg [READ_DELAY];
  logic [LEN_WIDTH-1:0]    tag_idx_reg   [READ_DELAY];
  logic [READ_DELAY-1:0]   tag_occ;

  logic                    load;
  logic                    issue;
  logic                    last_read;
  logic                    tags_pending;
  logic                    wr_fire;
  logic [LEN_WIDTH-1:0]    wr_idx;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  generate
    for (genvar gi = 0; gi < READ_DELAY; gi++) begin : g_occ
      assign tag_occ[gi] = tag_valid_reg[gi];
    end
  endgenerate

  assign tags_pending = |tag_occ;
  assign last_read    = (rd_cnt_reg == len_reg - LEN_WIDTH'(1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      commit_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      commit_cnt_reg <= commit_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    commit_cnt_next = commit_cnt_reg;
    busy            = 1'b0;
    done            = 1'b0;
    load            = 1'b0;
    issue           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_next = ST_DONE;
          end else begin
            load       = 1'b1;
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (last_read) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // The commit countdown only starts once the final write has left the tag pipeline.
        if (tags_pending) begin
          commit_cnt_next = '0;
        end else if (commit_cnt_reg == COMMIT_LAST) begin
          commit_cnt_next = '0;
          state_next      = ST_DONE;
        end else begin
          commit_cnt_next = commit_cnt_reg + CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- read side
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raddr_reg  <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      rd_cnt_reg <= '0;
    end else if (load) begin
      raddr_reg  <= src_addr & ALIGN_MASK;
      dst_reg    <= dst_addr & ALIGN_MASK;
      len_reg    <= len;
      rd_cnt_reg <= '0;
    end else if (issue) begin
      rd_cnt_reg <= rd_cnt_reg + LEN_WIDTH'(1);
      // raddr keeps the last issued address once the copy stops reading.
      if (!last_read) begin
        raddr_reg <= raddr_reg + ADDR_STEP;
      end
    end
  end

  assign raddr = raddr_reg;

  // ---------------------------------------------------------------- tag pipeline
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < READ_DELAY; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_idx_reg[s]   <= '0;
      end
    end else begin
      tag_valid_reg[0] <= issue;
      tag_idx_reg[0]   <= rd_cnt_reg;
      for (int s = 1; s < READ_DELAY; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_idx_reg[s]   <= tag_idx_reg[s-1];
      end
    end
  end

  // ---------------------------------------------------------------- write side
  // The write happens in the same cycle the read data returns, so rdata flows straight
  // through to wdata; the hold registers keep waddr/wdata stable between writes.
  assign wr_fire = tag_valid_reg[READ_DELAY-1];
  assign wr_idx  = tag_idx_reg[READ_DELAY-1];
  assign wr_addr = dst_reg + (ADDR_WIDTH'(wr_idx) << BYTE_SHIFT);

  assign waddr = wr_fire ? wr_addr : waddr_hold_reg;
  assign wdata = wr_fire ? rdata   : wdata_hold_reg;
  assign wstrb = wr_fire ? {BYTES{1'b1}} : {BYTES{1'b0}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waddr_hold_reg <= '0;
      wdata_hold_reg <= '0;
    end else begin
      waddr_hold_reg <= waddr;
      wdata_hold_reg <= wdata;
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: two engines (fast and slow RAM latency) share one stimulus stream,
// each with its own RAM model; a negedge monitor checks every cycle against queued copy requests.
module tb_ram_copy_engine;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 10;
  localparam int NI = 2;

  function automatic int rd_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int wd_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int            len;
    logic [31:0]   seed;
    int            start_cyc;
  } item_t;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  src_addr;
  logic [AW-1:0]  dst_addr;
  logic [LW-1:0]  len;

  logic           busy_w  [NI];
  logic           done_w  [NI];
  logic [AW-1:0]  raddr_w [NI];
  logic [AW-1:0]  waddr_w [NI];
  logic [3:0]     wstrb_w [NI];
  logic [31:0]    wdata_w [NI];
  logic [31:0]    rdata_w [NI];

  logic [31:0]    mem [NI][1024];
  logic           init_req;
  logic [31:0]    init_seed;

  int             cyc = 0;
  int             n_chk = 0;
  int             n_fail = 0;

  item_t          exp_q [$];
  int             head [NI];
  logic [AW-1:0]  last_raddr [NI];
  logic [AW-1:0]  last_waddr [NI];
  logic [31:0]    last_wdata [NI];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUTs and RAM models
  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int RDG = (gi == 0) ? 1 : 4;
      localparam int WDG = (gi == 0) ? 1 : 3;

      logic [AW-1:0] rp [RDG];
      logic          wv [WDG] = '{default: 1'b0};
      logic [AW-1:0] wa [WDG];
      logic [31:0]   wd [WDG];

      ram_copy_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .READ_DELAY (RDG),
        .WRITE_DELAY(WDG),
        .LEN_WIDTH  (LW)
      ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .len     (len),
        .busy    (busy_w[gi]),
        .done    (done_w[gi]),
        .raddr   (raddr_w[gi]),
        .waddr   (waddr_w[gi]),
        .wstrb   (wstrb_w[gi]),
        .wdata   (wdata_w[gi]),
        .rdata   (rdata_w[gi])
      );

      // Read returns READ_DELAY cycles after raddr; a write is readable WRITE_DELAY+1 cycles later.
      assign rdata_w[gi] = mem[gi][rp[RDG-1][AW-1:2]];

      always @(posedge clock) begin
        if (init_req) begin
          for (int a = 0; a < 1024; a++) mem[gi][a] <= init_seed + 32'(a);
        end else if (wv[WDG-1]) begin
          mem[gi][wa[WDG-1][AW-1:2]] <= wd[WDG-1];
        end
        rp[0] <= raddr_w[gi];
        wv[0] <= (wstrb_w[gi] == 4'hF);
        wa[0] <= waddr_w[gi];
        wd[0] <= wdata_w[gi];
        for (int s = 1; s < RDG; s++) rp[s] <= rp[s-1];
        for (int s = 1; s < WDG; s++) begin
          wv[s] <= wv[s-1];
          wa[s] <= wa[s-1];
          wd[s] <= wd[s-1];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_word(input item_t t, input int k);
    int idx;
    idx = (int'(t.src[AW-1:2]) + k) % 1024;
    return t.seed + 32'(idx);
  endfunction

  function automatic int done_rel(input item_t t, input int i);
    return (t.len == 0) ? 1 : t.len + rd_of(i) + wd_of(i) + 1;
  endfunction

  // ---------------------------------------------------------------- monitor / scoreboard
  always @(negedge clock) begin
    item_t          t;
    int             r;
    int             d;
    int             k;
    int             widx;
    logic [AW-1:0]  e_raddr;
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        // Reset aborts any copy in flight.
        head[i]       = exp_q.size();
        last_raddr[i] = '0;
        last_waddr[i] = '0;
        last_wdata[i] = '0;
      end else if (head[i] >= exp_q.size()) begin
        chk($sformatf("i%0d idle busy", i), 32'(busy_w[i]), 32'd0);
        chk($sformatf("i%0d idle done", i), 32'(done_w[i]), 32'd0);
        chk($sformatf("i%0d idle wstrb", i), 32'(wstrb_w[i]), 32'd0);
        chk($sformatf("i%0d idle raddr", i), 32'(raddr_w[i]), 32'(last_raddr[i]));
      end else begin
        t = exp_q[head[i]];
        r = cyc - t.start_cyc;
        d = done_rel(t, i);
        if (r >= 1) begin
          chk($sformatf("i%0d r%0d busy", i, r), 32'(busy_w[i]), 32'((t.len != 0) && (r < d)));
          chk($sformatf("i%0d r%0d done", i, r), 32'(done_w[i]), 32'(r == d));
          e_raddr = (t.len != 0 && r <= t.len) ? t.src + AW'((r - 1) * 4) : last_raddr[i];
          chk($sformatf("i%0d r%0d raddr", i, r), 32'(raddr_w[i]), 32'(e_raddr));
          last_raddr[i] = e_raddr;
          if (t.len != 0 && r >= rd_of(i) + 1 && r <= rd_of(i) + t.len) begin
            k = r - rd_of(i) - 1;
            last_waddr[i] = t.dst + AW'(k * 4);
            last_wdata[i] = src_word(t, k);
            chk($sformatf("i%0d r%0d wstrb", i, r), 32'(wstrb_w[i]), 32'hF);
          end else begin
            chk($sformatf("i%0d r%0d wstrb", i, r), 32'(wstrb_w[i]), 32'h0);
          end
          chk($sformatf("i%0d r%0d waddr", i, r), 32'(waddr_w[i]), 32'(last_waddr[i]));
          chk($sformatf("i%0d r%0d wdata", i, r), wdata_w[i], last_wdata[i]);
          if (r >= d) begin
            for (int m = 0; m < t.len; m++) begin
              widx = (int'(t.dst[AW-1:2]) + m) % 1024;
              chk($sformatf("i%0d mem[%0h]", i, widx), mem[i][widx], src_word(t, m));
            end
            widx = (int'(t.dst[AW-1:2]) + t.len) % 1024;
            chk($sformatf("i%0d mem[%0h] untouched", i, widx), mem[i][widx], t.seed + 32'(widx));
            $display("inst %0d: copy src=0x%03h dst=0x%03h len=%0d, done at cycle %0d", i, t.src,
                     t.dst, t.len, r);
            head[i]++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic mem_init(input logic [31:0] seed);
    @(negedge clock);
    init_seed = seed;
    init_req  = 1'b1;
    @(negedge clock);
    init_req  = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] dd, input int n,
                       input logic [31:0] seed, input bit expect_run);
    item_t t;
    @(negedge clock);
    src_addr = s;
    dst_addr = dd;
    len      = LW'(n);
    start    = 1'b1;
    if (expect_run) begin
      t.src       = s & 12'hFFC;
      t.dst       = dd & 12'hFFC;
      t.len       = n;
      t.seed      = seed;
      t.start_cyc = cyc;
      exp_q.push_back(t);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (head[0] >= exp_q.size() && head[1] >= exp_q.size()) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_idle: copy still outstanding after 300 cycles");
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d %s busy", i, tag), 32'(busy_w[i]), 32'd0);
      chk($sformatf("i%0d %s done", i, tag), 32'(done_w[i]), 32'd0);
      chk($sformatf("i%0d %s raddr", i, tag), 32'(raddr_w[i]), 32'd0);
      chk($sformatf("i%0d %s waddr", i, tag), 32'(waddr_w[i]), 32'd0);
      chk($sformatf("i%0d %s wstrb", i, tag), 32'(wstrb_w[i]), 32'd0);
      chk($sformatf("i%0d %s wdata", i, tag), wdata_w[i], 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len       = '0;
    init_req  = 1'b0;
    init_seed = '0;
    for (int i = 0; i < NI; i++) head[i] = 0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b1;

    // len = 0: done next cycle, no RAM traffic, raddr stays 0.
    mem_init(32'h1000);
    issue(12'h123, 12'h456, 0, 32'h1000, 1'b1);
    wait_idle();

    // Basic 8-word copy.
    issue(12'h000, 12'h400, 8, 32'h1000, 1'b1);
    wait_idle();

    // Start re-pulsed while busy is ignored; the later start (unaligned src) runs.
    mem_init(32'h2000);
    issue(12'h040, 12'h800, 6, 32'h2000, 1'b1);
    @(negedge clock);
    issue(12'h100, 12'hC00, 5, 32'h2000, 1'b0);
    wait_idle();
    issue(12'h102, 12'hC00, 5, 32'h2000, 1'b1);
    wait_idle();

    // Source range wraps past the top of the address space.
    mem_init(32'h4000);
    issue(12'hFF8, 12'h200, 4, 32'h4000, 1'b1);
    wait_idle();

    // Half-cycle reset in the middle of a 16-word copy, then a clean rerun.
    mem_init(32'h3000);
    issue(12'h000, 12'h600, 16, 32'h3000, 1'b1);
    repeat (8) @(posedge clock);
    #2;
    for (int i = 0; i < NI; i++) chk($sformatf("i%0d pre-abort wstrb", i), 32'(wstrb_w[i]), 32'hF);
    reset = 1'b0;
    #1;
    chk_reset_outputs("async-reset");
    #4;
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d partial first word", i), mem[i][12'h180], 32'h3000);
      chk($sformatf("i%0d partial last word", i), mem[i][12'h18F], 32'h318F);
    end
    issue(12'h000, 12'h600, 16, 32'h3000, 1'b1);
    wait_idle();

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
